// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU drive/return and response signals of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int XLEN    = 64,
    parameter int ALUOP_W = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [6:0]         req_opcode;
    logic [2:0]         req_funct3;
    logic [6:0]         req_funct7;
    logic [XLEN-1:0]    req_rs1;
    logic [XLEN-1:0]    req_rs2;
    logic [XLEN-1:0]    req_imm;
    logic [XLEN-1:0]    alu_a;
    logic [XLEN-1:0]    alu_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [XLEN-1:0]    alu_result;
    logic               alu_zero;
    logic               alu_a_bgt_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [XLEN-1:0]    rsp_result;
    logic               rsp_branch_taken;
    logic               rsp_illegal;

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_funct7, req_rs1, req_rs2, req_imm,
        input  alu_result, alu_zero, alu_a_bgt_b, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_branch_taken, rsp_illegal
    );

    modport master (
        output req_valid, req_opcode, req_funct3, req_funct7, req_rs1, req_rs2, req_imm,
        output alu_result, alu_zero, alu_a_bgt_b, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_branch_taken, rsp_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one RV64 ALU/branch request, drives the external ALU and returns its result.
module alu_issue_ctrl #(
    parameter int XLEN    = 64,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] issued_count_o
);
    localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(4'b0110);
    localparam logic [ALUOP_W-1:0] OP_SLL = ALUOP_W'(4'b1000);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    alu_a_q, alu_b_q, result_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         f3_q;
    logic               br_q, taken_q, illegal_q;
    logic               dec_legal, dec_br, br_taken, accept;
    logic [ALUOP_W-1:0] dec_op;
    logic [XLEN-1:0]    dec_b;

    always_comb begin
        dec_legal = 1'b0;
        dec_br    = 1'b0;
        dec_op    = OP_ADD;
        dec_b     = bus.req_rs2;
        case (bus.req_opcode)
            7'b0110011: begin
                dec_legal = (bus.req_funct7 == 7'b0000000 && (bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b111 || bus.req_funct3 == 3'b110))
                         || (bus.req_funct7 == 7'b0100000 && bus.req_funct3 == 3'b000);
                dec_op = bus.req_funct3 == 3'b111 ? OP_AND : bus.req_funct3 == 3'b110 ? OP_OR :
                         bus.req_funct7[5] ? OP_SUB : OP_ADD;
            end
            7'b0010011: begin
                dec_legal = bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b111 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b001;
                dec_op = bus.req_funct3 == 3'b111 ? OP_AND : bus.req_funct3 == 3'b110 ? OP_OR :
                         bus.req_funct3 == 3'b001 ? OP_SLL : OP_ADD;
                dec_b  = bus.req_funct3 == 3'b001 ? XLEN'(bus.req_imm[5:0]) : bus.req_imm;
            end
            7'b0000011, 7'b0100011: begin
                dec_legal = 1'b1;
                dec_b     = bus.req_imm;
            end
            7'b1100011: begin
                // signed blt/bge are unsupported: the ALU only reports an unsigned compare
                dec_legal = bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111;
                dec_br    = 1'b1;
                dec_op    = OP_SUB;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign accept   = state_q == IDLE && bus.req_valid;
    assign br_taken = br_q & (f3_q == 3'b000 ? bus.alu_zero :
                              f3_q == 3'b001 ? ~bus.alu_zero :
                              f3_q == 3'b110 ? ~bus.alu_zero & ~bus.alu_a_bgt_b :
                                               bus.alu_zero | bus.alu_a_bgt_b);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.req_valid ? (dec_legal ? EXEC : RESP) : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= OP_ADD;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            br_q      <= 1'b0;
            f3_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                result_q  <= '0;
                taken_q   <= 1'b0;
                illegal_q <= ~dec_legal;
                if (dec_legal) begin
                    alu_a_q  <= bus.req_rs1;
                    alu_b_q  <= dec_b;
                    alu_op_q <= dec_op;
                    br_q     <= dec_br;
                    f3_q     <= bus.req_funct3;
                    if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state_q == EXEC) begin
                result_q <= bus.alu_result;
                taken_q  <= br_taken;
            end
        end
    end

    assign bus.req_ready        = state_q == IDLE;
    assign bus.rsp_valid        = state_q == RESP;
    assign bus.rsp_result       = result_q;
    assign bus.rsp_branch_taken = taken_q;
    assign bus.rsp_illegal      = illegal_q;
    assign bus.alu_a            = alu_a_q;
    assign bus.alu_b            = alu_b_q;
    assign bus.alu_op           = alu_op_q;
    assign issued_count_o       = cnt_q;
endmodule
